// File: rtl/sysid_read_checker.sv
// sysid_read_checker: reads the system-ID (word 0) and timestamp (word 1) over Avalon-MM and compares them with expected values.
// Ports:
//   clock, reset                 - single clock, synchronous active-high reset
//   start                        - begin a check sequence (sampled in IDLE only)
//   avm_address, avm_read        - master request (word select, read strobe)
//   avm_waitrequest              - slave stall; a read is accepted when avm_read=1 and avm_waitrequest=0
//   avm_readdata, avm_readdatavalid - returned data and its qualifier
//   busy, done                   - sequence in progress, one-cycle end-of-sequence pulse
//   id_ok, ts_ok, timeout        - comparison results and timeout flag of the last sequence
//   read_id, read_ts             - captured words
module sysid_read_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] read_id,
    output logic [31:0] read_ts
);
    typedef enum logic [2:0] {IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FIN} state_t;
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);
    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_read, r_addr, r_busy, r_done, r_id_ok, r_ts_ok, r_timeout;
    logic [31:0] r_read_id, r_read_ts;
    logic        w_req, w_wait, w_ts, w_acc, w_rdv, w_tmo;
    assign w_req  = (r_state == ID_REQ) || (r_state == TS_REQ);
    assign w_wait = (r_state == ID_WAIT) || (r_state == TS_WAIT);
    assign w_ts   = (r_state == TS_REQ) || (r_state == TS_WAIT);
    assign w_acc  = w_req && !avm_waitrequest;
    // data only counts in a WAIT state or on the very cycle the request is accepted
    assign w_rdv  = avm_readdatavalid && (w_wait || w_acc);
    // r_cnt==LIMIT marks the TIMEOUT_CYCLES-th cycle of the current read
    assign w_tmo  = (w_req || w_wait) && !w_rdv && (r_cnt >= LIMIT);
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_read    <= 1'b0;
            r_addr    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_id_ok   <= 1'b0;
            r_ts_ok   <= 1'b0;
            r_timeout <= 1'b0;
            r_read_id <= '0;
            r_read_ts <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= ID_REQ;
                        r_cnt     <= '0;
                        r_read    <= 1'b1;
                        r_addr    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_id_ok   <= 1'b0;
                        r_ts_ok   <= 1'b0;
                        r_timeout <= 1'b0;
                        r_read_id <= '0;
                        r_read_ts <= '0;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_cnt <= (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
                    if (w_rdv && !w_ts) begin
                        r_read_id <= avm_readdata;
                        r_id_ok   <= (avm_readdata == EXPECTED_ID);
                        r_state   <= TS_REQ;
                        r_cnt     <= '0;
                        r_read    <= 1'b1;
                        r_addr    <= 1'b1;
                    end else if (w_rdv) begin
                        r_read_ts <= avm_readdata;
                        r_ts_ok   <= (avm_readdata == EXPECTED_TS);
                        r_state   <= FIN;
                        r_read    <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (w_tmo) begin
                        r_read    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_id_ok   <= w_ts ? r_id_ok : 1'b0;
                        r_ts_ok   <= 1'b0;
                        r_state   <= FIN;
                        r_done    <= 1'b1;
                    end else if (w_acc) begin
                        r_read  <= 1'b0;
                        r_state <= w_ts ? TS_WAIT : ID_WAIT;
                    end
                end
            endcase
        end
    end
    assign avm_read    = r_read;
    assign avm_address = r_addr;
    assign busy        = r_busy;
    assign done        = r_done;
    assign id_ok       = r_id_ok;
    assign ts_ok       = r_ts_ok;
    assign timeout     = r_timeout;
    assign read_id     = r_read_id;
    assign read_ts     = r_read_ts;
endmodule

// File: tb/tb_sysid_read_checker.sv
// tb_sysid_read_checker: directed bench for sysid_read_checker with a cycle-stepped Avalon-MM slave.
module tb_sysid_read_checker;
    localparam logic [31:0] EID = 32'h0000_0001;
    localparam logic [31:0] ETS = 32'h58CC_0F7E;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address, avm_read, busy, done, id_ok, ts_ok, timeout;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic [31:0] read_id, read_ts;
    int checks = 0;
    int errors = 0;

    sysid_read_checker #(.EXPECTED_ID(EID), .EXPECTED_TS(ETS), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset), .start(start),
        .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout),
        .read_id(read_id), .read_ts(read_ts)
    );

    always #5 clock = ~clock;

    // Slave: stalls ws cycles per read, returns data 1 cycle after acceptance (or same cycle if lat0).
    task automatic run_seq(input int ws, input bit lat0, input bit resp0, input bit resp1,
                           input logic [31:0] d0, input logic [31:0] d1, input int extra_start,
                           output int cyc, output int unstable, output int stalls,
                           output int post_act, output logic rd_at_done);
        int wcnt = 0;
        bit acc_last = 0;
        logic addr_last = 0, prev_read = 0, prev_addr = 0, prev_wr = 0;
        cyc = -1; unstable = 0; stalls = 0; post_act = 0; rd_at_done = 1'bx;
        start = 1'b1;
        for (int n = 1; n <= 40 && cyc < 0; n++) begin
            @(posedge clock); #1;
            start = (n == extra_start);
            if (done) begin
                cyc = n;
                rd_at_done = avm_read;
            end
            if (prev_read && prev_wr && (!avm_read || avm_address !== prev_addr)) unstable++;
            avm_readdatavalid = 1'b0;
            avm_readdata = 32'hDEAD_BEEF;
            if (acc_last && !lat0 && (addr_last ? resp1 : resp0)) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = addr_last ? d1 : d0;
            end
            if (avm_read) begin
                avm_waitrequest = (wcnt < ws);
                if (avm_waitrequest) begin
                    wcnt++;
                    stalls++;
                end else wcnt = 0;
            end else avm_waitrequest = 1'b0;
            if (lat0 && avm_read && !avm_waitrequest && (avm_address ? resp1 : resp0)) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = avm_address ? d1 : d0;
            end
            acc_last = avm_read && !avm_waitrequest;
            addr_last = avm_address;
            prev_read = avm_read;
            prev_addr = avm_address;
            prev_wr = avm_waitrequest;
        end
        start = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_waitrequest = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clock); #1;
            if (done || busy) post_act++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({avm_read, avm_address, busy, done, id_ok, ts_ok, timeout, read_id, read_ts} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b/%b/%b/%b/%b/%b/%b %h %h, expected all zero",
                     avm_read, avm_address, busy, done, id_ok, ts_ok, timeout, read_id, read_ts);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (busy !== 1'b0 || avm_read !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b avm_read=%b, expected 0 0", busy, avm_read);
        end
    endtask

    task automatic test_basic();
        int cyc, un, st, pa;
        logic rd;
        run_seq(0, 0, 1, 1, EID, ETS, -1, cyc, un, st, pa, rd);
        checks++;
        if (cyc < 5 || cyc > 7) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles, expected 5..7", cyc);
        end
        checks++;
        if ({id_ok, ts_ok, timeout} !== 3'b110) begin
            errors++;
            $display("FAIL basic_flags: got %b, expected 110", {id_ok, ts_ok, timeout});
        end
        checks++;
        if (read_id !== EID || read_ts !== ETS) begin
            errors++;
            $display("FAIL basic_data: got %h %h, expected %h %h", read_id, read_ts, EID, ETS);
        end
        checks++;
        if (pa !== 0) begin
            errors++;
            $display("FAIL basic_single_done: got %0d busy/done cycles after done, expected 0", pa);
        end
    endtask

    task automatic test_waitstates();
        int cyc, un, st, pa;
        logic rd;
        run_seq(3, 0, 1, 1, EID, ETS, -1, cyc, un, st, pa, rd);
        checks++;
        if (un !== 0 || st !== 6) begin
            errors++;
            $display("FAIL wait_stable: got %0d unstable, %0d stalls, expected 0, 6", un, st);
        end
        checks++;
        if (cyc !== 11) begin
            errors++;
            $display("FAIL wait_latency: got %0d cycles, expected 11", cyc);
        end
        checks++;
        if ({id_ok, ts_ok, timeout} !== 3'b110) begin
            errors++;
            $display("FAIL wait_flags: got %b, expected 110", {id_ok, ts_ok, timeout});
        end
    endtask

    task automatic test_ts_mismatch();
        int cyc, un, st, pa;
        logic rd;
        run_seq(0, 0, 1, 1, EID, 32'h0, -1, cyc, un, st, pa, rd);
        checks++;
        if (cyc !== 5) begin
            errors++;
            $display("FAIL ts_zero_done: got %0d cycles, expected 5", cyc);
        end
        checks++;
        if ({id_ok, ts_ok, timeout} !== 3'b100 || read_ts !== 32'h0) begin
            errors++;
            $display("FAIL ts_zero_flags: got %b ts=%h, expected 100 ts=0", {id_ok, ts_ok, timeout}, read_ts);
        end
    endtask

    task automatic test_skip_wait();
        int cyc, un, st, pa;
        logic rd;
        run_seq(0, 1, 1, 1, 32'h0000_0002, ETS, -1, cyc, un, st, pa, rd);
        checks++;
        if (cyc !== 3) begin
            errors++;
            $display("FAIL skip_wait_latency: got %0d cycles, expected 3", cyc);
        end
        checks++;
        if ({id_ok, ts_ok, timeout} !== 3'b010 || read_id !== 32'h2) begin
            errors++;
            $display("FAIL skip_wait_flags: got %b id=%h, expected 010 id=2", {id_ok, ts_ok, timeout}, read_id);
        end
    endtask

    task automatic test_timeout();
        int cyc, un, st, pa;
        logic rd;
        run_seq(0, 0, 0, 1, EID, ETS, -1, cyc, un, st, pa, rd);
        checks++;
        if (cyc < 1 || cyc > 10) begin
            errors++;
            $display("FAIL timeout_done: got %0d cycles, expected 1..10", cyc);
        end
        checks++;
        if ({id_ok, ts_ok, timeout} !== 3'b001 || rd !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flags: got %b read=%b, expected 001 read=0", {id_ok, ts_ok, timeout}, rd);
        end
        run_seq(100, 0, 1, 1, EID, ETS, -1, cyc, un, st, pa, rd);
        checks++;
        if (cyc < 1 || cyc > 10 || rd !== 1'b0 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_stall: got cyc=%0d read=%b timeout=%b, expected cyc<=10 read=0 timeout=1",
                     cyc, rd, timeout);
        end
        checks++;
        if (avm_read !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: got read=%b busy=%b, expected 0 0", avm_read, busy);
        end
    endtask

    task automatic test_start_while_busy();
        int cyc, un, st, pa;
        logic rd;
        run_seq(0, 0, 1, 1, EID, ETS, 2, cyc, un, st, pa, rd);
        checks++;
        if (cyc !== 5 || pa !== 0) begin
            errors++;
            $display("FAIL busy_start: got cyc=%0d post=%0d, expected 5 0", cyc, pa);
        end
        checks++;
        if ({id_ok, ts_ok, timeout} !== 3'b110) begin
            errors++;
            $display("FAIL busy_start_flags: got %b, expected 110", {id_ok, ts_ok, timeout});
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        start = 1'b1;
        avm_waitrequest = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (busy !== 1'b1 || avm_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait: got busy=%b read=%b, expected 1 0", busy, avm_read);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++;
        if ({avm_read, avm_address, busy, done, id_ok, ts_ok, timeout, read_id, read_ts} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b%b%b%b%b%b%b, expected all zero",
                     avm_read, avm_address, busy, done, id_ok, ts_ok, timeout);
        end
        avm_readdatavalid = 1'b1;
        avm_readdata = EID;
        for (int n = 0; n < 4; n++) begin
            @(posedge clock); #1;
            if (done || busy || id_ok || read_id !== 32'h0) bad++;
        end
        avm_readdatavalid = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_mid_late_data: got %0d active cycles, expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_waitstates();
        test_ts_mismatch();
        test_skip_wait();
        test_timeout();
        test_start_while_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sysid_read_checker.md
SYSID_READ_CHECKER -- requirements
Module: sysid_read_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'h0000_0000, meaning the value expected at system-ID word 0.
REQ-002 SHALL have parameter EXPECTED_TS, default 32'h0000_0000, meaning the value expected at timestamp word 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, range 1..65535, meaning the maximum cycles allowed per read.
REQ-004 SHALL have port clock, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning the reset, which is synchronous and active-high.
REQ-006 SHALL have port start, input, 1, meaning a request for a check sequence, sampled in IDLE only.
REQ-007 SHALL have port avm_address, output, 1, meaning the word select (0=ID, 1=timestamp).
REQ-008 SHALL have port avm_read, output, 1, meaning the Avalon-MM read request.
REQ-009 SHALL have port avm_waitrequest, input, 1, meaning the slave stall; a read is accepted on a cycle with avm_read=1 and avm_waitrequest=0.
REQ-010 SHALL have port avm_readdata, input, 32, meaning the read data.
REQ-011 SHALL have port avm_readdatavalid, input, 1, meaning avm_readdata is valid this cycle.
REQ-012 SHALL have port busy, output, 1, meaning the sequence is in progress (any state except IDLE).
REQ-013 SHALL have port done, output, 1, meaning a one-cycle pulse at the end of the sequence (pass, fail or timeout).
REQ-014 SHALL have ports id_ok and ts_ok, outputs, 1 each, meaning the corresponding captured word equalled its expected value.
REQ-015 SHALL have port timeout, output, 1, meaning the last sequence aborted on timeout.
REQ-016 SHALL have ports read_id and read_ts, outputs, 32 each, meaning the captured words.

Function
REQ-017 SHALL implement states IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FIN.
REQ-018 SHALL, in IDLE with start=1, clear id_ok, ts_ok, timeout, read_id and read_ts, then enter ID_REQ next cycle.
REQ-019 SHALL ignore start in every state other than IDLE.
REQ-020 SHALL, in ID_REQ/TS_REQ, drive avm_read=1 with avm_address=0/1 and hold both stable until acceptance.
REQ-021 SHALL, on acceptance without readdatavalid, drive avm_read=0 next cycle and move to ID_WAIT/TS_WAIT.
REQ-022 SHALL, when readdatavalid coincides with acceptance, capture the data that cycle and skip the WAIT state.
REQ-023 SHALL, on readdatavalid in ID_WAIT, capture read_id, set id_ok=(avm_readdata==EXPECTED_ID), and enter TS_REQ.
REQ-024 SHALL, on readdatavalid in TS_WAIT, capture read_ts, set ts_ok=(avm_readdata==EXPECTED_TS), and enter FIN.
REQ-025 SHALL ignore avm_readdatavalid in IDLE, FIN, and any REQ cycle without acceptance.
REQ-026 SHALL, in FIN, assert done=1 for exactly one cycle and return to IDLE next cycle.
REQ-027 SHALL use a 16-bit timeout counter, cleared on entry to each REQ state and incremented every cycle in REQ/WAIT, never wrapping.
REQ-028 SHALL, when the counter reaches TIMEOUT_CYCLES with no readdatavalid, drop avm_read, set timeout=1, clear the ok flag of the pending word, and go to FIN.
REQ-029 SHALL give readdatavalid priority over timeout when both occur in the same cycle.
REQ-030 SHALL hold id_ok, ts_ok, timeout, read_id and read_ts constant from FIN until the next accepted start.

Reset
REQ-031 SHALL, with reset=1 at a clock edge, enter IDLE and drive avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, read_id=0, read_ts=0, and counter=0.
REQ-032 SHALL, on reset mid-sequence, abandon the outstanding read without a done pulse, and ignore any later readdatavalid.

Verification
REQ-033 SHALL cover: EXPECTED_ID=32'h1, EXPECTED_TS=32'h58CC_0F7E, zero-wait slave, data 1 latency 1 -> done pulse 5-7 cycles after start, id_ok=1, ts_ok=1, timeout=0.
REQ-034 SHALL cover: waitrequest held 3 cycles per read -> avm_read/avm_address stable those 3 cycles, result still pass.
REQ-035 SHALL cover: timestamp returns 32'h0 -> id_ok=1, ts_ok=0, read_ts=0, done pulse.
REQ-036 SHALL cover: TIMEOUT_CYCLES=8, slave never asserts readdatavalid for address 0 -> avm_read deasserted, timeout=1, id_ok=0, done within 10 cycles of start.
REQ-037 SHALL cover: start pulsed while busy, and reset asserted during ID_WAIT -> extra start ignored; after reset all outputs 0, no done, late readdatavalid ignored.
